// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave with LATENCY wait states,
// byte-lane stores and extended sub-word loads. Optional macro: DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        lat_f3;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready depends only on state and reset, never on req_valid.
    assign req_ready = (state == S_IDLE) && !reset;
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_next   = 4'(LATENCY);
                    state_next = (LATENCY > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) state_next = S_RESP;
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // With zero latency the access edge is the accept edge, so use the live request then.
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [2:0]        acc_f3;
    logic              access;

    assign acc_we    = (state == S_IDLE) ? req_we     : lat_we;
    assign acc_addr  = (state == S_IDLE) ? req_addr   : lat_addr;
    assign acc_wdata = (state == S_IDLE) ? req_wdata  : lat_wdata;
    assign acc_f3    = (state == S_IDLE) ? req_funct3 : lat_f3;
    assign access    = (state_next == S_RESP) && !reset;

    logic [IDX_W-1:0]  idx;
    logic [MEM_AW-1:0] mem_idx;
    logic [1:0]        lane;
    logic              in_range;
    logic              f3_ok;
    logic              misaligned;
    logic              acc_err;

    assign idx      = acc_addr[ADDR_W-1:2];
    assign mem_idx  = MEM_AW'(idx);
    assign lane     = acc_addr[1:0];
    assign in_range = 32'(idx) < DEPTH_WORDS;
    assign f3_ok    = acc_we ? (acc_f3 inside {3'b000, 3'b001, 3'b010})
                             : !(acc_f3 inside {3'b011, 3'b110, 3'b111});

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                        ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign acc_err = !f3_ok || !in_range || misaligned;

    logic [DATA_W-1:0] word;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] load_v;

    assign word   = mem[mem_idx];
    assign byte_v = word[8*lane +: 8];
    assign half_v = acc_addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_v = '0;
        case (acc_f3)
            3'b000:  load_v = {{(DATA_W-8){byte_v[7]}}, byte_v};
            3'b001:  load_v = {{(DATA_W-16){half_v[15]}}, half_v};
            3'b010:  load_v = word;
            3'b100:  load_v = {{(DATA_W-8){1'b0}}, byte_v};
            3'b101:  load_v = {{(DATA_W-16){1'b0}}, half_v};
            default: load_v = '0;
        endcase
    end

    // Store data is replicated across lanes; byte enables pick which lanes land.
    logic [3:0]        be;
    logic [DATA_W-1:0] wd;

    always_comb begin
        be = 4'b0000;
        wd = acc_wdata;
        case (acc_f3[1:0])
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be = acc_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{acc_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (access && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[mem_idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_f3    <= 3'b000;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if ((state == S_IDLE) && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_f3    <= req_funct3;
            end
            if (access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_we || acc_err) ? '0 : load_v;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random load/store traffic against a
// behavioural memory model; honours DMEM_MISALIGN_TRAP_EN when defined.
module tb_dmem_responder;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 64;
    localparam int LAT    = 2;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_funct3;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_q[$];

    dmem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: words as plain integers, lanes handled with shifts and masks.
    task automatic model(input bit we, input logic [8:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rd, output bit err);
        int          idx  = int'(addr) / 4;
        int          sh8  = 8 * (int'(addr) % 4);
        int          sh16 = 16 * ((int'(addr) / 2) % 2);
        logic [31:0] w, v, mask;
        rd  = 32'h0;
        err = 0;
        if (idx >= DEPTH) err = 1;
        if (we && f3 > 3'd2) err = 1;
        if (!we && (f3 == 3'd3 || f3 >= 3'd6)) err = 1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((f3 % 4) == 1 && (addr % 2) != 0) err = 1;
        if ((f3 % 4) == 2 && (addr % 4) != 0) err = 1;
`endif
        if (err) return;
        w = ref_mem[6'(idx)];
        if (we) begin
            if (f3 == 3'd0) begin
                mask = 32'hFF << sh8;
                w = (w & ~mask) | ((wdata & 32'hFF) << sh8);
            end else if (f3 == 3'd1) begin
                mask = 32'hFFFF << sh16;
                w = (w & ~mask) | ((wdata & 32'hFFFF) << sh16);
            end else begin
                w = wdata;
            end
            ref_mem[6'(idx)] = w;
        end else begin
            case (f3)
                3'd0: begin v = (w >> sh8) & 32'hFF;    rd = (v >= 128)   ? (v | 32'hFFFFFF00) : v; end
                3'd1: begin v = (w >> sh16) & 32'hFFFF; rd = (v >= 32768) ? (v | 32'hFFFF0000) : v; end
                3'd2: rd = w;
                3'd4: rd = (w >> sh8) & 32'hFF;
                3'd5: rd = (w >> sh16) & 32'hFFFF;
                default: rd = 32'h0;
            endcase
        end
    endtask

    // One full transaction: wait for ready, accept, then check every cycle until idle again.
    task automatic do_req(input bit we, input logic [8:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          n;
        model(we, addr, wdata, f3, exp_rd, exp_err);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_idle", req_ready, 1);
        req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            check("busy_after_accept", busy, 1);
            check("ready_while_busy", req_ready, 0);
            if (k <= LAT) check("rsp_early", rsp_valid, 0);
        end
        check("rsp_valid", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", rsp_err, 32'(exp_err));
        @(negedge clk);
        check("rsp_one_cycle", rsp_valid, 0);
        check("ready_after_rsp", req_ready, 1);
        check("busy_after_rsp", busy, 0);
    endtask

    task automatic drive_load(input logic [8:0] addr, input logic [2:0] f3);
        logic [31:0] rd;
        bit          e;
        req_we = 1'b0; req_addr = addr; req_funct3 = f3; req_wdata = $urandom;
        model(1'b0, addr, 32'h0, f3, rd, e);
        exp_q.push_back(rd);
    endtask

    initial begin
        logic [8:0]  bb_addr [3];
        logic [2:0]  bb_f3   [3];
        int          acc_cyc [8];
        int          acc_n, pulses, viol, nxt, seen;
        bit          accepting;
        logic [8:0]  ra;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_funct3 = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        reset = 1'b0;
        #1 check("ready_after_rst", req_ready, 1);

        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 9'(i * 4), $urandom, 3'd2);

        // Word store/load, then byte store over a known word and every extension.
        do_req(1'b1, 9'h010, 32'hDEADBEEF, 3'd2);
        do_req(1'b0, 9'h010, 32'h0, 3'd2);
        do_req(1'b1, 9'h010, 32'h11223344, 3'd2);
        do_req(1'b1, 9'h013, 32'h00000080, 3'd0);
        do_req(1'b0, 9'h010, 32'h0, 3'd2);
        do_req(1'b0, 9'h013, 32'h0, 3'd0);
        do_req(1'b0, 9'h013, 32'h0, 3'd4);
        do_req(1'b0, 9'h012, 32'h0, 3'd1);
        do_req(1'b0, 9'h012, 32'h0, 3'd5);
        check("sb_word_value", ref_mem[4], 32'h80223344);

        // Illegal funct3, out-of-range index, misaligned word store.
        do_req(1'b0, 9'h010, 32'h0, 3'd3);
        do_req(1'b1, 9'h014, 32'h55AA55AA, 3'd3);
        do_req(1'b1, 9'h1FC, 32'hA5A5A5A5, 3'd2);
        do_req(1'b0, 9'h0FC, 32'h0, 3'd2);
        do_req(1'b0, 9'h1FC, 32'h0, 3'd2);
        do_req(1'b1, 9'h021, 32'hCAFEF00D, 3'd2);
        do_req(1'b0, 9'h020, 32'h0, 3'd2);
        do_req(1'b1, 9'h027, 32'h0000BEEF, 3'd1);
        do_req(1'b0, 9'h024, 32'h0, 3'd2);

        // req_valid held high across three requests.
        bb_addr = '{9'h010, 9'h013, 9'h022};
        bb_f3   = '{3'd2, 3'd0, 3'd5};
        acc_n = 0; pulses = 0; viol = 0;
        @(negedge clk);
        drive_load(bb_addr[0], bb_f3[0]);
        req_valid = 1'b1;
        nxt = 1;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid) begin
                pulses++;
                if (exp_q.size() > 0) check("bb_rdata", rsp_rdata, exp_q.pop_front());
                else check("bb_extra_rsp", rsp_valid, 0);
            end
            if (busy && req_ready) viol++;
            accepting = req_valid && req_ready;
            if (accepting && acc_n < 8) begin
                acc_cyc[acc_n] = c;
                acc_n++;
            end
            @(posedge clk);
            #1;
            if (accepting) begin
                if (nxt < 3) begin
                    drive_load(bb_addr[nxt], bb_f3[nxt]);
                    nxt++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("bb_accepts", acc_n, 3);
        if (acc_n == 3) begin
            check("bb_spacing_1", acc_cyc[1] - acc_cyc[0], LAT + 2);
            check("bb_spacing_2", acc_cyc[2] - acc_cyc[1], LAT + 2);
        end
        check("bb_ready_while_busy", viol, 0);
        check("bb_pulses", pulses, 3);
        check("bb_queue_empty", exp_q.size(), 0);

        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(7) == 0) ? 9'($urandom_range(511)) : 9'($urandom_range(255));
            do_req(1'($urandom_range(1)), ra, $urandom, 3'($urandom_range(7)));
        end

        // Reset one cycle after a store accept: the store never lands.
        do_req(1'b0, 9'h010, 32'h0, 3'd2);
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            req_we = 1'b1; req_addr = 9'h030; req_wdata = 32'h12345678;
            req_funct3 = 3'd2; req_valid = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            seen = 0;
            // pass 0: reset sampled on the edge after accept; pass 1: on the access edge
            for (int k = 0; k < pass; k++) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            @(negedge clk);
            reset = 1'b1;
            repeat (2) begin
                @(negedge clk);
                if (rsp_valid) seen++;
                check("ready_in_reset", req_ready, 0);
            end
            reset = 1'b0;
            #1;
            check("post_rst_ready", req_ready, 1);
            check("post_rst_busy", busy, 0);
            check("post_rst_rdata", rsp_rdata, 0);
            check("post_rst_err", rsp_err, 0);
            repeat (4) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            check("no_rsp_after_rst", seen, 0);
            do_req(1'b0, 9'h030, 32'h0, 3'd2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
